// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - two-stage elastic immediate sign/zero/shift/upper extension pipe
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHL   = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // S1: raw item as accepted from decode
  logic             v1_q, v1_d;
  logic [IN_W-1:0]  imm1_q, imm1_d;
  logic [1:0]       mode1_q, mode1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // S2: extended result presented to the consumer
  logic             v2_q, v2_d;
  logic [OUT_W-1:0] data2_q, data2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic             adv1, adv2, accept;
  logic [OUT_W-1:0] sext, zext, result;

  // A stage may load when it is empty or its occupant moves on this cycle
  assign adv2     = !v2_q | out_ready;
  assign adv1     = !v1_q | adv2;
  assign in_ready = adv1 & !reset & !flush;
  assign accept   = in_valid & in_ready;

  assign out_valid = v2_q;
  assign out_data  = data2_q;
  assign out_tag   = tag2_q;
  assign busy      = v1_q | v2_q;

  // Extension of the S1 immediate according to its mode
  always_comb begin
    sext   = {{(OUT_W-IN_W){imm1_q[IN_W-1]}}, imm1_q};
    zext   = {{(OUT_W-IN_W){1'b0}}, imm1_q};
    result = sext;
    unique case (mode1_q)
      2'b00: result = sext;
      2'b01: result = zext;
      2'b10: result = sext << SHL;
      2'b11: result = zext << (OUT_W - IN_W);
    endcase
  end

  // Next state of both stages; flush only clears the valid bits
  always_comb begin
    v1_d    = v1_q;
    imm1_d  = imm1_q;
    mode1_d = mode1_q;
    tag1_d  = tag1_q;
    v2_d    = v2_q;
    data2_d = data2_q;
    tag2_d  = tag2_q;
    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        imm1_d  = in_imm;
        mode1_d = in_mode;
        tag1_d  = in_tag;
      end
    end
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        data2_d = result;
        tag2_d  = tag1_q;
      end
    end
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end
  end

  // Pipeline registers; reset clears everything and wins over flush
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      imm1_q  <= '0;
      mode1_q <= '0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      data2_q <= '0;
      tag2_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      imm1_q  <= imm1_d;
      mode1_q <= mode1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      data2_q <= data2_d;
      tag2_q  <= tag2_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - scoreboard bench for imm_ext_pipe
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .SHL(2), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] x, input logic [1:0] m);
    logic signed [31:0] s;
    s = 32'($signed(x));
    case (m)
      2'b00:   return s;
      2'b01:   return {16'h0000, x};
      2'b10:   return s * 4;
      default: return {x, 16'h0000};
    endcase
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_tag", 32'(out_tag), 32'(e.tag));
      end
    end
    if (reset || flush) sb_q.delete();
    else if (in_valid && in_ready) begin
      e.tag  = in_tag;
      e.data = model(in_imm, in_mode);
      sb_q.push_back(e);
    end
  end

  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    bit ok = 1'b0;
    int n  = 0;
    in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = in_ready;
      n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size() == 0 && !busy), 32'd1);
    @(posedge clk); #1;
  endtask

  logic [15:0] bp_imm [3];
  logic [1:0]  bp_mode[3];
  int          idx;
  bit          acc;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_imm = '0; in_mode = '0; in_tag = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Test 1: latency and sign/zero extension
    send(16'h8001, 2'b00, 5'd1);
    @(negedge clk);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    check("lat_edge1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_edge2_data", out_data, 32'hFFFF8001);
    @(posedge clk); #1;
    wait_drain();
    send(16'h8001, 2'b01, 5'd2);
    wait_drain();

    // Test 2: shift, load-upper, positive sign-ext
    send(16'hFFFE, 2'b10, 5'd3);
    send(16'h1234, 2'b11, 5'd4);
    send(16'h7FFF, 2'b00, 5'd5);
    wait_drain();

    // Test 3: back-to-back stream of 8
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_imm = 16'($urandom); in_mode = 2'($urandom_range(0, 3)); in_tag = 5'(k);
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      check("stream_out_valid", 32'(out_valid), 32'(k >= 2));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 8; k < 11; k++) begin
      @(negedge clk);
      check("stream_tail_valid", 32'(out_valid), 32'(k < 10));
      @(posedge clk); #1;
    end
    wait_drain();

    // Test 4: backpressure with in_valid held
    bp_imm[0] = 16'hA001; bp_mode[0] = 2'b00;
    bp_imm[1] = 16'h00F0; bp_mode[1] = 2'b10;
    bp_imm[2] = 16'hC3C3; bp_mode[2] = 2'b11;
    out_ready = 1'b0; idx = 0;
    in_valid = 1'b1; in_imm = bp_imm[0]; in_mode = bp_mode[0]; in_tag = 5'd10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'(c < 2));
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin in_imm = bp_imm[idx]; in_mode = bp_mode[idx]; in_tag = 5'(10 + idx); end
      end
    end
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 32'(idx), 32'd3);
    wait_drain();

    // Test 5: flush with two items in flight
    out_ready = 1'b0;
    send(16'h1111, 2'b00, 5'd20);
    send(16'h2222, 2'b01, 5'd21);
    flush = 1'b1; in_valid = 1'b1; in_imm = 16'h3333; in_mode = 2'b00; in_tag = 5'd22;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h4444, 2'b10, 5'd23);
    wait_drain();

    // Test 6: reset mid-stream with out_ready low
    out_ready = 1'b0;
    send(16'h5A5A, 2'b11, 5'd24);
    send(16'h8888, 2'b00, 5'd25);
    reset = 1'b1; in_valid = 1'b1; in_imm = 16'h9999; in_tag = 5'd26;
    @(negedge clk);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_data", out_data, 32'd0);
    check("rst_mid_out_tag", 32'(out_tag), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_in_ready2", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    send(16'h0F0F, 2'b10, 5'd27);
    wait_drain();

    // Mode sweep with random immediates
    for (int k = 0; k < 12; k++) send(16'($urandom), 2'(k % 4), 5'(k));
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
